// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI card-side command responder.
// The CRC7 helper is only used when SD_SPI_CRC7_CHECK_EN is defined.
package sd_pkg;

  localparam int unsigned SD_CMD_LEN = 48;

  localparam logic [7:0] R1_IDLE        = 8'h01;
  localparam logic [7:0] R1_ILLEGAL_CMD = 8'h04;
  localparam logic [7:0] R1_CRC_ERR     = 8'h08;

  // Unused response bits after an auto-generated R1 are padded with ones.
  localparam logic [39:0] RSP_PAD = 40'hFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_RECV,
    ST_CHECK,
    ST_WAIT_CORE,
    ST_GAP,
    ST_SEND
  } sd_state_e;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator with clear, enable and data-in.
// A clear together with enable restarts the sum from the incoming bit.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       res,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_din,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc7_step(i_clr ? 7'h00 : r_crc, i_din);
    end else if (i_clr) begin
      r_crc <= '0;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sd_spi_card_resp.sv
// Card-side SD SPI command responder: receives 48-bit frames, hands them to a core, returns a 48-bit response.
// Define SD_SPI_CRC7_CHECK_EN to check CRC7 on incoming frames; otherwise only framing is checked.
module sd_spi_card_resp
  import sd_pkg::*;
#(
  parameter int unsigned NCR = 2
) (
  input  logic        clk,
  input  logic        res,
  input  logic        card_MOSI,
  input  logic        card_CS,
  output logic        card_MISO,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  input  logic        rsp_valid,
  input  logic [47:0] rsp_data,
  output logic        busy
);

  localparam logic [2:0] GAP_LAST = 3'(NCR - 1);

  sd_state_e             r_state, w_state_nx;
  logic [5:0]            r_bit_cnt, w_bit_cnt_nx;
  logic [2:0]            r_gap_cnt, w_gap_cnt_nx;
  logic [SD_CMD_LEN-1:0] r_frame, w_frame_nx;
  logic [SD_CMD_LEN-1:0] r_rsp, w_rsp_nx;
  logic                  r_miso, w_miso_nx;
  logic                  r_cmd_valid, w_cmd_valid_nx;
  logic [5:0]            r_cmd_index, w_cmd_index_nx;
  logic [31:0]           r_cmd_arg, w_cmd_arg_nx;
  logic                  r_busy;

  logic w_start, w_frame_ok, w_crc_err, w_unused_bits;

  assign w_start    = card_CS & ~card_MOSI;
  assign w_frame_ok = r_frame[46] & r_frame[0];

`ifdef SD_SPI_CRC7_CHECK_EN
  logic [6:0] w_crc;
  logic       w_crc_clr, w_crc_en;

  // CRC covers frame bits 47..8: the start bit in HUNT, then RECV down to bit 8.
  assign w_crc_clr = (r_state == ST_HUNT) & w_start;
  assign w_crc_en  = w_crc_clr | ((r_state == ST_RECV) & card_CS & (r_bit_cnt >= 6'd8));

  sd_crc7 u_crc7 (
    .clk   (clk),
    .res   (res),
    .i_clr (w_crc_clr),
    .i_en  (w_crc_en),
    .i_din (card_MOSI),
    .o_crc (w_crc)
  );

  assign w_crc_err     = (w_crc != r_frame[7:1]);
  assign w_unused_bits = r_frame[47];
`else
  assign w_crc_err     = 1'b0;
  assign w_unused_bits = ^{r_frame[47], r_frame[7:1]};
`endif

  always_comb begin
    // NOTE: every next-state signal gets its default first, so no path can infer a latch.
    w_state_nx     = r_state;
    w_bit_cnt_nx   = r_bit_cnt;
    w_gap_cnt_nx   = r_gap_cnt;
    w_frame_nx     = r_frame;
    w_rsp_nx       = r_rsp;
    w_miso_nx      = r_miso;
    w_cmd_valid_nx = r_cmd_valid;
    w_cmd_index_nx = r_cmd_index;
    w_cmd_arg_nx   = r_cmd_arg;

    unique case (r_state)
      ST_HUNT: begin
        if (w_start) begin
          w_frame_nx   = {{(SD_CMD_LEN-1){1'b0}}, card_MOSI};
          w_bit_cnt_nx = 6'd46;
          w_state_nx   = ST_RECV;
        end
      end
      ST_RECV: begin
        if (!card_CS) begin
          w_bit_cnt_nx = '0;
          w_state_nx   = ST_HUNT;
        end else begin
          w_frame_nx = {r_frame[SD_CMD_LEN-2:0], card_MOSI};
          if (r_bit_cnt == 6'd0) begin
            w_state_nx = ST_CHECK;
          end else begin
            w_bit_cnt_nx = r_bit_cnt - 6'd1;
          end
        end
      end
      ST_CHECK: begin
        w_gap_cnt_nx = '0;
        if (!w_frame_ok) begin
          w_rsp_nx   = {R1_ILLEGAL_CMD, RSP_PAD};
          w_state_nx = ST_GAP;
        end else if (w_crc_err) begin
          w_rsp_nx   = {R1_CRC_ERR, RSP_PAD};
          w_state_nx = ST_GAP;
        end else begin
          w_cmd_index_nx = r_frame[45:40];
          w_cmd_arg_nx   = r_frame[39:8];
          w_cmd_valid_nx = 1'b1;
          w_state_nx     = ST_WAIT_CORE;
        end
      end
      ST_WAIT_CORE: begin
        if (rsp_valid) begin
          w_rsp_nx       = rsp_data;
          w_cmd_valid_nx = 1'b0;
          w_gap_cnt_nx   = '0;
          w_state_nx     = ST_GAP;
        end
      end
      ST_GAP: begin
        // The last gap edge already loads bit 47, so MISO idles for exactly NCR cycles.
        if (r_gap_cnt == GAP_LAST) begin
          w_miso_nx    = r_rsp[47];
          w_bit_cnt_nx = 6'd47;
          w_gap_cnt_nx = '0;
          w_state_nx   = ST_SEND;
        end else begin
          w_gap_cnt_nx = r_gap_cnt + 3'd1;
        end
      end
      ST_SEND: begin
        if (r_bit_cnt == 6'd0) begin
          w_miso_nx  = 1'b1;
          w_state_nx = ST_HUNT;
        end else begin
          w_miso_nx    = r_rsp[r_bit_cnt - 6'd1];
          w_bit_cnt_nx = r_bit_cnt - 6'd1;
        end
      end
      default: begin
        w_state_nx = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state     <= ST_HUNT;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_frame     <= '0;
      r_rsp       <= '0;
      r_miso      <= 1'b1;
      r_cmd_valid <= 1'b0;
      r_cmd_index <= '0;
      r_cmd_arg   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_gap_cnt   <= w_gap_cnt_nx;
      r_frame     <= w_frame_nx;
      r_rsp       <= w_rsp_nx;
      r_miso      <= w_miso_nx;
      r_cmd_valid <= w_cmd_valid_nx;
      r_cmd_index <= w_cmd_index_nx;
      r_cmd_arg   <= w_cmd_arg_nx;
      r_busy      <= (w_state_nx != ST_HUNT);
    end
  end

  assign card_MISO = r_miso;
  assign cmd_valid = r_cmd_valid;
  assign cmd_index = r_cmd_index;
  assign cmd_arg   = r_cmd_arg;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sd_spi_card_resp.sv
// Scoreboard bench for sd_spi_card_resp: drivers push expected commands/responses,
// monitors pop and compare when cmd_valid rises or a response starts on MISO.
module tb_sd_spi_card_resp;

  localparam int NCR = 2;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        card_MOSI = 1'b1;
  logic        card_CS = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [47:0] rsp_data = '0;
  logic        card_MISO, cmd_valid, busy;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  sd_spi_card_resp #(.NCR(NCR)) dut (
    .clk       (clk),
    .res       (res),
    .card_MOSI (card_MOSI),
    .card_CS   (card_CS),
    .card_MISO (card_MISO),
    .cmd_valid (cmd_valid),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          cyc;
  } cmd_exp_t;

  typedef struct {
    logic [47:0] data;
    int          cyc;
  } rsp_exp_t;

  cmd_exp_t cmd_q[$];
  rsp_exp_t rsp_q[$];

  bit mon_en     = 1'b0;
  bit abort_rsp  = 1'b0;
  bit collecting = 1'b0;
  bit post_check = 1'b0;
  int e0;

  // Command monitor: compares fields and latency on each rising cmd_valid.
  logic     prev_cv = 1'b0;
  cmd_exp_t ce;
  always @(negedge clk) begin
    if (mon_en && !res && cmd_valid && !prev_cv) begin
      if (cmd_q.size() == 0) begin
        check("cmd_valid_unexpected", cmd_valid, 1'b0);
      end else begin
        ce = cmd_q.pop_front();
        check("cmd_index", cmd_index, ce.idx);
        check("cmd_arg", cmd_arg, ce.arg);
        check("cmd_valid_cycle", cyc, ce.cyc);
      end
    end
    prev_cv = cmd_valid;
  end

  // Response monitor: a 0 on idle MISO starts a 48-bit response.
  logic [47:0] sh;
  int          nbits;
  rsp_exp_t    re;
  always @(negedge clk) begin
    if (!mon_en || res || abort_rsp) begin
      collecting = 1'b0;
      post_check = 1'b0;
    end else if (collecting) begin
      sh = {sh[46:0], card_MISO};
      nbits++;
      if (nbits == 48) begin
        check("rsp_data", sh, re.data);
        collecting = 1'b0;
        post_check = 1'b1;
      end
    end else if (post_check) begin
      check("miso_idle_after_rsp", card_MISO, 1'b1);
      check("busy_low_after_rsp", busy, 1'b0);
      post_check = 1'b0;
    end else if (card_MISO == 1'b0) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", card_MISO, 1'b1);
      end else begin
        re = rsp_q.pop_front();
        check("rsp_start_cycle", cyc, re.cyc);
        sh         = {47'b0, card_MISO};
        nbits      = 1;
        collecting = 1'b1;
      end
    end
  end

  task automatic send_frame(input logic [47:0] f, input int cs_bits);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (i == 0) e0 = cyc + 1;
      card_CS   = (i < cs_bits);
      card_MOSI = (i < cs_bits) ? f[47-i] : 1'b1;
    end
    @(negedge clk);
    card_CS   = 1'b0;
    card_MOSI = 1'b1;
  endtask

  task automatic wait_cmd();
    for (int k = 0; k < 100 && !cmd_valid; k++) @(negedge clk);
    check("cmd_valid_seen", cmd_valid, 1'b1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && (busy || collecting || post_check || cmd_valid); k++) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic cmd_core(input logic [47:0] f, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [47:0] rsp, input int hold);
    send_frame(f, 48);
    cmd_q.push_back('{idx, arg, e0 + 48});
    wait_cmd();
    repeat (hold) @(negedge clk);
    rsp_data  = rsp;
    rsp_valid = 1'b1;
    rsp_q.push_back('{rsp, cyc + 1 + NCR});
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_data  = '0;
    wait_idle();
  endtask

  // Auto-response path; rsp_valid is held high throughout and must be ignored.
  task automatic cmd_auto(input logic [47:0] f, input logic [47:0] exp_rsp);
    rsp_data  = '0;
    rsp_valid = 1'b1;
    send_frame(f, 48);
    rsp_q.push_back('{exp_rsp, e0 + 48 + NCR});
    wait_idle();
    rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int r_edge;

  initial begin
    res = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_miso", card_MISO, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_cmd_valid", cmd_valid, 1'b0);
    check("reset_cmd_index", cmd_index, 6'd0);
    check("reset_cmd_arg", cmd_arg, 32'd0);
    res    = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    cmd_core(48'h40_0000_0000_95, 6'd0,  32'h0000_0000, 48'h01_FFFF_FFFF_FF, 3);
    cmd_core(48'h48_0000_01AA_87, 6'd8,  32'h0000_01AA, 48'h01_0000_01AA_FF, 0);
    cmd_core(48'h69_4000_0000_77, 6'd41, 32'h4000_0000, 48'h00_FFFF_FFFF_FF, 1);
    cmd_core(48'h7A_0000_0000_FD, 6'd58, 32'h0000_0000, 48'h00_C0FF_8000_FF, 2);

`ifdef SD_SPI_CRC7_CHECK_EN
    cmd_auto(48'h40_0000_0000_97, 48'h08_FFFF_FFFF_FF);
`else
    cmd_core(48'h40_0000_0000_97, 6'd0, 32'h0000_0000, 48'h01_FFFF_FFFF_FF, 0);
`endif

    cmd_auto(48'h40_0000_0000_94, 48'h04_FFFF_FFFF_FF);
    cmd_auto(48'h00_0000_0000_95, 48'h04_FFFF_FFFF_FF);

    send_frame(48'h40_0000_0000_95, 20);
    repeat (2) @(negedge clk);
    check("abort_busy", busy, 1'b0);
    check("abort_cmd_valid", cmd_valid, 1'b0);
    cmd_core(48'h40_0000_0000_95, 6'd0, 32'h0000_0000, 48'h01_FFFF_FFFF_FF, 0);

    // Reset while MISO carries response bit 30.
    send_frame(48'h48_0000_01AA_87, 48);
    cmd_q.push_back('{6'd8, 32'h0000_01AA, e0 + 48});
    wait_cmd();
    rsp_data  = 48'h01_0000_01AA_FF;
    rsp_valid = 1'b1;
    r_edge    = cyc + 1;
    rsp_q.push_back('{48'h01_0000_01AA_FF, r_edge + NCR});
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_data  = '0;
    while (cyc < r_edge + NCR + 17) @(negedge clk);
    check("busy_during_send", busy, 1'b1);
    abort_rsp = 1'b1;
    res       = 1'b1;
    @(negedge clk);
    check("midsend_reset_miso", card_MISO, 1'b1);
    check("midsend_reset_busy", busy, 1'b0);
    check("midsend_reset_cmd_valid", cmd_valid, 1'b0);
    check("midsend_reset_cmd_index", cmd_index, 6'd0);
    check("midsend_reset_cmd_arg", cmd_arg, 32'd0);
    res = 1'b0;
    @(negedge clk);
    abort_rsp = 1'b0;
    repeat (2) @(negedge clk);

    cmd_core(48'h40_0000_0000_95, 6'd0, 32'h0000_0000, 48'h01_FFFF_FFFF_FF, 1);

    repeat (5) @(negedge clk);
    check("cmd_queue_drained", cmd_q.size(), 0);
    check("rsp_queue_drained", rsp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
